// File: rtl/wb_pwm_capture.sv
// Wishbone B4 pipelined slave measuring high time and period of PWM inputs.
// Each channel synchronizes its input, times rise-to-rise and latches HIGH/PER.
module wb_pwm_capture #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 3
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  input  logic [CHANNELS-1:0] pwm_i
);

  localparam logic [WIDTH-1:0] MaxCnt    = '1;
  localparam logic [WIDTH-1:0] OneCnt    = WIDTH'(1);
  localparam logic [31:0]      StatusAdr = 32'(2 * CHANNELS);

  typedef enum logic {Arm, Measure} chanState_e;

  logic [CHANNELS-1:0] sync1_q, lvl_q, prev_q;
  logic [CHANNELS-1:0] rise, satEvt, ovfClr;
  chanState_e          state_q [CHANNELS];
  chanState_e          state_d [CHANNELS];
  logic [WIDTH-1:0]    hcnt_q [CHANNELS];
  logic [WIDTH-1:0]    hcnt_d [CHANNELS];
  logic [WIDTH-1:0]    pcnt_q [CHANNELS];
  logic [WIDTH-1:0]    pcnt_d [CHANNELS];
  logic [WIDTH-1:0]    high_q [CHANNELS];
  logic [WIDTH-1:0]    high_d [CHANNELS];
  logic [WIDTH-1:0]    per_q [CHANNELS];
  logic [WIDTH-1:0]    per_d [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [CHANNELS-1:0] valid_q, valid_d, ovf_q, ovf_d;
  logic                busReq, rdReq, wrStatus;
  logic [31:0]         statusWord, rdData;
  logic [31:0]         dat_q;
  logic                ack_q;
  logic                unusedDatBits;

  assign busReq        = wb_cyc_i & wb_stb_i;
  assign rdReq         = busReq & ~wb_we_i;
  assign wrStatus      = busReq & wb_we_i & (wb_adr_i == StatusAdr);
  assign ovfClr        = wrStatus ? wb_dat_i[2*CHANNELS-1:CHANNELS] : '0;
  assign rise          = lvl_q & ~prev_q;
  assign unusedDatBits = ^{wb_dat_i[31:2*CHANNELS], wb_dat_i[CHANNELS-1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_q <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pwm_i;
      lvl_q   <= sync1_q;
      prev_q  <= lvl_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= Arm;
    end else begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (state_q[i] == Arm && rise[i]) state_d[i] = Measure;
    end
  end

  // Saturation fires once, on the cycle pcnt steps onto the clamp value.
  always_comb begin
    satEvt = '0;
    for (int i = 0; i < CHANNELS; i++)
      satEvt[i] = (state_q[i] == Measure) && (pcnt_q[i] == MaxCnt - OneCnt);
  end

  always_comb begin
    valid_d = valid_q;
    ovf_d   = (ovf_q & ~ovfClr) | satEvt;
    for (int i = 0; i < CHANNELS; i++) begin
      hcnt_d[i]   = hcnt_q[i];
      pcnt_d[i]   = pcnt_q[i];
      high_d[i]   = high_q[i];
      per_d[i]    = per_q[i];
      shadow_d[i] = shadow_q[i];
      if (rdReq && wb_adr_i == 32'(2 * i)) shadow_d[i] = per_q[i];
      if (state_q[i] == Arm) begin
        if (rise[i]) begin
          hcnt_d[i] = OneCnt;
          pcnt_d[i] = OneCnt;
        end
      end else if (rise[i]) begin
        high_d[i]  = hcnt_q[i];
        per_d[i]   = pcnt_q[i];
        valid_d[i] = 1'b1;
        hcnt_d[i]  = OneCnt;
        pcnt_d[i]  = OneCnt;
      end else begin
        pcnt_d[i] = (pcnt_q[i] == MaxCnt) ? MaxCnt : pcnt_q[i] + OneCnt;
        hcnt_d[i] = (lvl_q[i] && hcnt_q[i] != MaxCnt) ? hcnt_q[i] + OneCnt : hcnt_q[i];
        if (satEvt[i]) valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hcnt_q[i]   <= '0;
        pcnt_q[i]   <= '0;
        high_q[i]   <= '0;
        per_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < CHANNELS; i++) begin
        hcnt_q[i]   <= hcnt_d[i];
        pcnt_q[i]   <= pcnt_d[i];
        high_q[i]   <= high_d[i];
        per_q[i]    <= per_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  always_comb begin
    statusWord = '0;
    statusWord[CHANNELS-1:0]            = valid_q;
    statusWord[2*CHANNELS-1:CHANNELS]   = ovf_q;
    statusWord[3*CHANNELS-1:2*CHANNELS] = lvl_q;
    rdData = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wb_adr_i == 32'(2 * i))     rdData = 32'(high_q[i]);
      if (wb_adr_i == 32'(2 * i + 1)) rdData = 32'(shadow_q[i]);
    end
    if (wb_adr_i == StatusAdr) rdData = statusWord;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= busReq;
      dat_q <= rdReq ? rdData : '0;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;

endmodule

// File: doc/wb_pwm_capture.md
Name: wb_pwm_capture

Overview:
Wishbone B4 pipelined slave that measures incoming PWM signals. It is the capture-side counterpart of the PWM generator. For each channel it reports the high time and the period, in clock cycles, between consecutive rising edges. It also provides per-channel valid, overflow and level status, so software can read back the duty cycle of external or looped-back PWM outputs.

Parameters:
WIDTH, 16, bit width of the high-time and period counters (1..32); maximum count is 2^WIDTH-1.
CHANNELS, 3, number of PWM inputs measured (1..10; 3*CHANNELS must be <= 32).

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  asynchronous active-low reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  word address
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_ack_o  out  1  acknowledge
wb_stall_o  out  1  stall, tied 0
pwm_i  in  CHANNELS  asynchronous PWM inputs

Behaviour:
- Reset (wb_rst_ni low, asynchronous): every flop clears, taking effect immediately.
  - wb_ack_o=0, wb_dat_o=0.
  - All counters, latched values, shadows, valid, ovf and synchronizers are 0.
  - Every channel returns to ARM.
- Input path: 2-flop synchronizer per channel giving lvl[i], plus a prev flop. Rise = lvl & ~prev. Input-to-detection latency is 3 cycles.
- Per-channel FSM:
  - ARM: count nothing. On rise, set hcnt=1, pcnt=1 and go to MEASURE. Nothing is latched.
  - MEASURE, non-rise cycle:
    - pcnt <= sat(pcnt+1).
    - hcnt <= sat(hcnt+lvl).
    - sat clamps at 2^WIDTH-1.
  - MEASURE, rise cycle:
    - HIGH[i] <= hcnt, PER[i] <= pcnt, valid[i] <= 1.
    - Then hcnt=1, pcnt=1.
  - Result: input high H synced cycles and low L cycles gives HIGH=H, PER=H+L.
- Saturation: on the cycle pcnt becomes 2^WIDTH-1, ovf[i] is set (sticky) and valid[i] is cleared. This covers a stalled 0% or 100% input. The channel stays in MEASURE. The next rise latches the clamped values and sets valid again.
- Register map (word addresses, i = 0..CHANNELS-1):
  - 2*i, read: returns HIGH[i], zero-extended. The same cycle, PER[i] is copied into SHADOW[i].
  - 2*i+1, read: returns SHADOW[i] (tear-free pair: read 2*i first).
  - 2*CHANNELS, read: STATUS. [C-1:0]=valid, [2C-1:C]=ovf, [3C-1:2C]=lvl, other bits 0.
  - 2*CHANNELS, write: W1C of ovf using wb_dat_i[2C-1:C]. All other bits are ignored.
  - Writes to any other address are ignored. Reads of unmapped addresses return 0.
- Handshake:
  - wb_ack_o <= cyc & stb every cycle, so there is one-cycle latency and back-to-back requests are accepted.
  - wb_dat_o is valid in the ack cycle.
  - wb_stall_o is always 0.
  - A request while cyc is low is ignored; no ack is generated.
- Simultaneous events:
  - Saturation set and W1C clear of ovf in the same cycle: set wins.
  - Latch and read of HIGH[i] in the same cycle: the read returns the old HIGH and shadows the old PER.
  - Rise in the saturation cycle: the latch takes priority, valid=1, and ovf is set.
- Reset during a bus cycle: the ack is dropped. The master must reissue the request.

Test Plan:
- WIDTH=16, C=3. ch0 driven 3 high / 5 low repeatedly. After the second detected rise, read adr 0 -> 3, adr 1 -> 8, STATUS bit0=1; ack one cycle after each stb.
- ch1 held high after one rise for 65535+ cycles -> STATUS valid[1]=0, ovf[1]=1, lvl[1]=1. Next rise -> HIGH=PER=0xFFFF, valid[1]=1.
- Write STATUS with bit C+1 set -> ovf[1] clears, other ovf bits unchanged. Same write on a saturation cycle -> ovf stays 1.
- Read adr 0 (value 3, period 8), change ch0 to 2/2, wait for a new latch, read adr 1 -> 8 (shadow), not 4.
- Back-to-back reads adr 0,1,6 with stb high 3 cycles -> 3 acks on consecutive cycles, correct data each; write to adr 0 -> no state change; read adr 7 -> 0.
- Assert wb_rst_ni low mid-measurement and during stb -> ack and dat_o 0 immediately. After release, the first rise only arms, and valid stays 0 until the second rise.
